// File: rtl/window_gen_5x5_if.sv
// Streaming interface for the 5x5 window generator: raster pixel input and
// registered window output, each with a valid/ready handshake.
interface window_gen_5x5_if #(
  parameter int unsigned DATA_W = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [25*DATA_W-1:0]  win_data;
  logic                  out_last;

  // master: pixel source and window sink; slave: the window generator
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, win_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, win_data, out_last
  );
endinterface

// File: rtl/window_gen_5x5.sv
// Raster-scan 5x5 sliding-window generator with four line buffers and a
// one-deep registered output. Optional window counter: WINDOW_GEN_COUNT_EN.
module window_gen_5x5 #(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  window_gen_5x5_if.slave   bus
`ifdef WINDOW_GEN_COUNT_EN
  ,
  output logic [15:0]       win_count
`endif
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic [DATA_W-1:0] line_q [4][IMG_W];
  logic [DATA_W-1:0] win_q  [5][5];
  logic [DATA_W-1:0] tap    [4];
  logic [DATA_W-1:0] new_col[5];

  logic accept, qualify, col_end, row_end, out_hs;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_hs       = out_valid_q && bus.out_ready;
  assign col_end      = (col_q == ColW'(IMG_W - 1));
  assign row_end      = (row_q == RowW'(IMG_H - 1));
  assign qualify      = accept && (row_q >= RowW'(4)) && (col_q >= ColW'(4));

  // tap[0] is the row just above the incoming pixel, tap[3] the oldest row
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tap[i] = line_q[i][col_q];
    end
    new_col[0] = tap[3];
    new_col[1] = tap[2];
    new_col[2] = tap[1];
    new_col[3] = tap[0];
    new_col[4] = bus.in_data;
  end

  // Position counters
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Output handshake: a new qualifying pixel reloads, otherwise a taken window clears
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (qualify) begin
      out_valid_d = 1'b1;
      out_last_d  = row_end && col_end;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffers are not reset; stale rows are never visible before being rewritten
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      line_q[0][col_q] <= bus.in_data;
      for (int i = 1; i < 4; i++) begin
        line_q[i][col_q] <= tap[i-1];
      end
    end
  end

  // Window array doubles as the registered output; it only moves on accepted pixels
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][4] <= new_col[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        bus.win_data[DATA_W*(5*r+c) +: DATA_W] = win_q[r][c];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

`ifdef WINDOW_GEN_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (out_hs) begin
      count_d = out_last_q ? 16'd0 : count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign win_count = count_q;
`endif

endmodule

// File: tb/tb_window_gen_5x5.sv
// Directed bench for window_gen_5x5 on an 8x8 image with pixel value r*8+c;
// expected windows come from the pixel position of the qualifying pixel.
module tb_window_gen_5x5;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;
  localparam int unsigned DW = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // model state
  bit   m_ov;
  int   m_row, m_col, w_r, w_c, m_cnt, wins;

  window_gen_5x5_if #(.DATA_W(DW)) bus ();

`ifdef WINDOW_GEN_COUNT_EN
  logic [15:0] win_count;
`endif

  window_gen_5x5 #(
    .IMG_W (W),
    .IMG_H (H),
    .DATA_W(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef WINDOW_GEN_COUNT_EN
    ,
    .win_count(win_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [149:0] got, input logic [149:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [149:0] exp_win(input int r, input int c);
    logic [149:0] v;
    v = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        v[DW*(5*i+j) +: DW] = DW'((r - 4 + i) * W + (c - 4 + j));
      end
    end
    return v;
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic cyc(input logic v, input logic rdy);
    bit acc, qual, hs, last;
    bus.in_valid  = v;
    bus.in_data   = DW'(m_row * W + m_col);
    bus.out_ready = rdy;
    #1;
    last = m_ov && (w_r == H - 1) && (w_c == W - 1);
    chk("in_ready", bus.in_ready, !m_ov || rdy);
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_last", bus.out_last, last);
    if (m_ov) chk("win_data", bus.win_data, exp_win(w_r, w_c));
`ifdef WINDOW_GEN_COUNT_EN
    chk("win_count", win_count, m_cnt);
`endif
    hs   = m_ov && rdy;
    acc  = v && (!m_ov || rdy);
    qual = acc && (m_row >= 4) && (m_col >= 4);
    if (hs) begin
      wins++;
      m_cnt = last ? 0 : (m_cnt + 1) % 65536;
    end
    m_ov = qual ? 1'b1 : (m_ov && !rdy);
    if (qual) begin
      w_r = m_row;
      w_c = m_col;
    end
    if (acc) begin
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous; 1: first window stalled 5 cycles; 2: in_valid toggles 1/0
  task automatic run_pixels(input int mode, input int npix);
    int  got   = 0;
    int  guard = 0;
    int  stall = 5;
    bit  ph    = 1'b1;
    logic v, r;
    while (got < npix && guard < 1000) begin
      v  = (mode == 2) ? ph : 1'b1;
      ph = !ph;
      r  = 1'b1;
      if (mode == 1 && m_ov && stall > 0) begin
        r = 1'b0;
        stall--;
      end
      if (v && (!m_ov || r)) got++;
      cyc(v, r);
      guard++;
    end
    chk("pixel_budget", got, npix);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ov  = 1'b0;
    m_row = 0;
    m_col = 0;
    m_cnt = 0;
    w_r   = 0;
    w_c   = 0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_win_data", bus.win_data, '0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
`ifdef WINDOW_GEN_COUNT_EN
    chk("rst_win_count", win_count, 16'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Continuous frame
    wins = 0;
    run_pixels(0, 64);
    chk("frame_windows", wins, 16);

    // Stall the first window for 5 cycles
    wins = 0;
    run_pixels(1, 64);
    chk("stall_windows", wins, 16);

    // in_valid alternating
    wins = 0;
    run_pixels(2, 64);
    chk("toggle_windows", wins, 16);

    // Abort mid-frame, then a clean frame
    run_pixels(0, 20);
    do_reset();
    wins = 0;
    run_pixels(0, 64);
    chk("post_reset_windows", wins, 16);

    // Two back-to-back frames
    wins = 0;
    run_pixels(0, 128);
    chk("two_frame_windows", wins, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
